byte_deser: RTL and testbench



---
 rtl/byte_deser.sv | 184 ++++++++++++++++++
 tb/tb_byte_deser.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_deser.sv
// Framed serial-to-parallel deserializer with a one-word valid/ready holding buffer and sticky overrun/frame flags.
// Define BYTE_DESER_PARITY_EN to append an even-parity bit to each frame and report it on par_err.
module byte_deser #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             sin_start,
   input  logic             out_ready,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             overrun,
`ifdef BYTE_DESER_PARITY_EN
   output logic             par_err,
`endif
   output logic             frame_err
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef BYTE_DESER_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;

   logic [WIDTH-1:0] shift_in;
   logic [WIDTH-1:0] word;
   logic             offer;
   logic             abort;
   logic             load;

`ifdef BYTE_DESER_PARITY_EN
   logic             par_new;
   logic             par_err_q, par_err_d;
`endif

   // Shift register with sin inserted; stale bits from an aborted frame fall off the far end.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (LSB_FIRST) begin : g_lsb
            if (gi == WIDTH - 1) begin : g_in
               assign shift_in[gi] = sin;
            end else begin : g_mv
               assign shift_in[gi] = shreg_q[gi+1];
            end
         end else begin : g_msb
            if (gi == 0) begin : g_in
               assign shift_in[gi] = sin;
            end else begin : g_mv
               assign shift_in[gi] = shreg_q[gi-1];
            end
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      word    = shift_in;
      offer   = 1'b0;
      abort   = 1'b0;
`ifdef BYTE_DESER_PARITY_EN
      par_new = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (sin_valid && sin_start) begin
               shreg_d = shift_in;
               cnt_d   = CW'(1);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (sin_valid) begin
               shreg_d = shift_in;
               if (sin_start) begin
                  abort = 1'b1;
                  cnt_d = CW'(1);
               end else if (cnt_q == CW'(WIDTH - 1)) begin
                  cnt_d = '0;
`ifdef BYTE_DESER_PARITY_EN
                  state_d = ST_PARITY;
`else
                  offer   = 1'b1;
                  state_d = ST_IDLE;
`endif
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
`ifdef BYTE_DESER_PARITY_EN
         ST_PARITY: begin
            if (sin_valid) begin
               if (sin_start) begin
                  abort   = 1'b1;
                  shreg_d = shift_in;
                  cnt_d   = CW'(1);
                  state_d = ST_SHIFT;
               end else begin
                  offer   = 1'b1;
                  word    = shreg_q;
                  par_new = (^shreg_q) ^ sin;
                  state_d = ST_IDLE;
               end
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A held word that is being consumed on this edge frees the buffer for the new one.
   always_comb begin
      load        = offer && (!out_valid_q || out_ready);
      out_valid_d = load || (out_valid_q && !out_ready);
      out_data_d  = load ? word : out_data_q;
      overrun_d   = (offer && out_valid_q && !out_ready) || (overrun_q && !clr_flags);
      frame_err_d = abort || (frame_err_q && !clr_flags);
`ifdef BYTE_DESER_PARITY_EN
      par_err_d   = load ? par_new : par_err_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef BYTE_DESER_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
`ifdef BYTE_DESER_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
`ifdef BYTE_DESER_PARITY_EN
   assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_byte_deser.sv
// Directed bench for byte_deser: an MSB-first and an LSB-first instance share one serial stream.
// With BYTE_DESER_PARITY_EN defined every frame carries an even-parity bit.
module tb_byte_deser;

   logic       clk;
   logic       rst;
   logic       sin;
   logic       sin_valid;
   logic       sin_start;
   logic       out_ready;
   logic       clr_flags;
   logic [7:0] m_data, l_data;
   logic       m_valid, l_valid;
   logic       m_ovr, l_ovr;
   logic       m_ferr, l_ferr;
`ifdef BYTE_DESER_PARITY_EN
   logic       m_perr, l_perr;
`endif

   int n_cmp = 0;
   int n_err = 0;

   byte_deser #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
      .out_ready(out_ready), .clr_flags(clr_flags), .out_data(m_data), .out_valid(m_valid),
      .overrun(m_ovr),
`ifdef BYTE_DESER_PARITY_EN
      .par_err(m_perr),
`endif
      .frame_err(m_ferr)
   );

   byte_deser #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
      .out_ready(out_ready), .clr_flags(clr_flags), .out_data(l_data), .out_valid(l_valid),
      .overrun(l_ovr),
`ifdef BYTE_DESER_PARITY_EN
      .par_err(l_perr),
`endif
      .frame_err(l_ferr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input logic st);
      sin       = b;
      sin_valid = 1'b1;
      sin_start = st;
      @(negedge clk);
      sin_valid = 1'b0;
      sin_start = 1'b0;
   endtask

   // Sends positions from..to of w in transmit order; position 0 carries sin_start.
   task automatic send_bits(input logic [7:0] w, input bit lsb, input int from, input int to);
      for (int i = from; i <= to; i++) begin
         send_bit(lsb ? w[i] : w[7-i], i == 0);
      end
   endtask

   task automatic send_parity(input logic [7:0] w);
`ifdef BYTE_DESER_PARITY_EN
      send_bit(^w, 1'b0);
`else
      if (w === 8'hxx) step();
`endif
   endtask

   task automatic send_word(input logic [7:0] w);
      send_bits(w, 1'b0, 0, 7);
      send_parity(w);
   endtask

   task automatic test_reset();
      rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0;
      out_ready = 1'b0; clr_flags = 1'b0;
      step(); step();
      n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", m_data); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
      n_cmp++; if (m_ovr !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", m_ovr); end
      n_cmp++; if (m_ferr !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b expected 0", m_ferr); end
      n_cmp++; if (l_valid !== 1'b0) begin n_err++; $display("FAIL reset_lsb_valid: got %b expected 0", l_valid); end
      rst = 1'b0;
      step();
      $display("test_reset done");
   endtask

   task automatic test_msb_word();
      out_ready = 1'b1;
      send_bits(8'hA5, 1'b0, 0, 6);
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL msb_early_valid: got %b expected 0", m_valid); end
      send_bits(8'hA5, 1'b0, 7, 7);
`ifdef BYTE_DESER_PARITY_EN
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL msb_par_latency: got %b expected 0", m_valid); end
`endif
      send_parity(8'hA5);
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL msb_valid: got %b expected 1", m_valid); end
      n_cmp++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL msb_data: got %h expected a5", m_data); end
      step();
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL msb_valid_one_cycle: got %b expected 0", m_valid); end
      n_cmp++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL msb_data_kept: got %h expected a5", m_data); end
      $display("test_msb_word done: data=%h", m_data);
   endtask

   task automatic test_stall_lsb();
      out_ready = 1'b1;
      send_bits(8'h3C, 1'b1, 0, 2);
      step(); step(); step();
      send_bits(8'h3C, 1'b1, 3, 5);
      step(); step(); step();
      n_cmp++; if (l_valid !== 1'b0) begin n_err++; $display("FAIL stall_early_valid: got %b expected 0", l_valid); end
      send_bits(8'h3C, 1'b1, 6, 7);
      send_parity(8'h3C);
      n_cmp++; if (l_valid !== 1'b1) begin n_err++; $display("FAIL stall_lsb_valid: got %b expected 1", l_valid); end
      n_cmp++; if (l_data !== 8'h3C) begin n_err++; $display("FAIL stall_lsb_data: got %h expected 3c", l_data); end
      n_cmp++; if (m_data !== 8'h3C) begin n_err++; $display("FAIL stall_msb_data: got %h expected 3c", m_data); end
      step();
      $display("test_stall_lsb done: data=%h", l_data);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send_word(8'h11);
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_valid: got %b expected 1", m_valid); end
      n_cmp++; if (m_ovr !== 1'b0) begin n_err++; $display("FAIL bp_no_overrun: got %b expected 0", m_ovr); end
      send_word(8'h22);
      n_cmp++; if (m_data !== 8'h11) begin n_err++; $display("FAIL bp_data_held: got %h expected 11", m_data); end
      n_cmp++; if (l_data !== 8'h88) begin n_err++; $display("FAIL bp_lsb_data_held: got %h expected 88", l_data); end
      n_cmp++; if (m_ovr !== 1'b1) begin n_err++; $display("FAIL bp_overrun: got %b expected 1", m_ovr); end
      out_ready = 1'b1;
      step();
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL bp_consumed: got %b expected 0", m_valid); end
      n_cmp++; if (m_data !== 8'h11) begin n_err++; $display("FAIL bp_data_after: got %h expected 11", m_data); end
      n_cmp++; if (m_ovr !== 1'b1) begin n_err++; $display("FAIL bp_overrun_sticky: got %b expected 1", m_ovr); end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      n_cmp++; if (m_ovr !== 1'b0) begin n_err++; $display("FAIL bp_overrun_clr: got %b expected 0", m_ovr); end
      $display("test_backpressure done: data=%h", m_data);
   endtask

   task automatic test_resync();
      out_ready = 1'b1;
      send_bits(8'hFF, 1'b0, 0, 4);
      send_bits(8'h81, 1'b0, 0, 6);
      n_cmp++; if (m_ferr !== 1'b1) begin n_err++; $display("FAIL resync_frame_err: got %b expected 1", m_ferr); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL resync_no_aborted_word: got %b expected 0", m_valid); end
      send_bits(8'h81, 1'b0, 7, 7);
      send_parity(8'h81);
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL resync_valid: got %b expected 1", m_valid); end
      n_cmp++; if (m_data !== 8'h81) begin n_err++; $display("FAIL resync_data: got %h expected 81", m_data); end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      n_cmp++; if (m_ferr !== 1'b0) begin n_err++; $display("FAIL resync_clr: got %b expected 0", m_ferr); end
      // Abort coinciding with clr_flags: the set must win.
      send_bits(8'h81, 1'b0, 0, 2);
      clr_flags = 1'b1;
      send_bits(8'hA5, 1'b0, 0, 0);
      clr_flags = 1'b0;
      n_cmp++; if (m_ferr !== 1'b1) begin n_err++; $display("FAIL resync_set_dominant: got %b expected 1", m_ferr); end
      send_bits(8'hA5, 1'b0, 1, 7);
      send_parity(8'hA5);
      n_cmp++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL resync2_data: got %h expected a5", m_data); end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      $display("test_resync done: data=%h", m_data);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send_word(8'h5A);
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rmid_held: got %b expected 1", m_valid); end
      send_bits(8'hC3, 1'b0, 0, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", m_valid); end
      n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h expected 00", m_data); end
      n_cmp++; if (m_ovr !== 1'b0) begin n_err++; $display("FAIL rmid_overrun: got %b expected 0", m_ovr); end
      n_cmp++; if (m_ferr !== 1'b0) begin n_err++; $display("FAIL rmid_frame_err: got %b expected 0", m_ferr); end
      out_ready = 1'b1;
      send_bit(1'b1, 1'b0);
      send_word(8'h5A);
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rmid_after_valid: got %b expected 1", m_valid); end
      n_cmp++; if (m_data !== 8'h5A) begin n_err++; $display("FAIL rmid_after_data: got %h expected 5a", m_data); end
      n_cmp++; if (m_ferr !== 1'b0) begin n_err++; $display("FAIL rmid_after_frame_err: got %b expected 0", m_ferr); end
      step();
      $display("test_reset_mid done: data=%h", m_data);
   endtask

`ifdef BYTE_DESER_PARITY_EN
   task automatic test_parity();
      out_ready = 1'b1;
      send_bits(8'hA5, 1'b0, 0, 7);
      send_bit(1'b0, 1'b0);
      n_cmp++; if (m_perr !== 1'b0) begin n_err++; $display("FAIL par_good: got %b expected 0", m_perr); end
      n_cmp++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL par_good_data: got %h expected a5", m_data); end
      step();
      send_bits(8'hA5, 1'b0, 0, 7);
      send_bit(1'b1, 1'b0);
      n_cmp++; if (m_perr !== 1'b1) begin n_err++; $display("FAIL par_bad: got %b expected 1", m_perr); end
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL par_bad_valid: got %b expected 1", m_valid); end
      n_cmp++; if (m_data !== 8'hA5) begin n_err++; $display("FAIL par_bad_data: got %h expected a5", m_data); end
      step();
      $display("test_parity done: par_err=%b", m_perr);
   endtask
`endif

   initial begin
      test_reset();
      test_msb_word();
      test_stall_lsb();
      test_backpressure();
      test_resync();
      test_reset_mid();
`ifdef BYTE_DESER_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
